// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states
// and the byte-lane mask used by partial stores.
package dmem_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_MERGE,
    ST_RESP
  } state_t;

  // Little-endian lanes: bit k of the mask selects bits [8k+7:8k].
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_WORD: lane_mask = 4'b1111;
      SZ_HALF: lane_mask = offset[1] ? 4'b1100 : 4'b0011;
      SZ_BYTE: lane_mask = 4'b0001 << offset;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_merge.sv
// Combinational read-modify-write merge: overlays the store data onto the
// old word in the byte lanes selected by size and byte offset.
module dmem_lane_merge
  import dmem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  output logic [31:0] merged
);

  logic [3:0]  mask;
  logic [31:0] lanes;

  always_comb begin
    // NOTE: every output of a combinational block gets a default up front so
    // no path can leave it unassigned and infer a latch.
    merged = old_word;
    mask   = lane_mask(size, offset);
    case (size)
      SZ_BYTE: lanes = {4{wdata[7:0]}};
      SZ_HALF: lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) merged[8*k +: 8] = lanes[8*k +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready, served
// from an internal word array after WAIT_CYCLES wait states. Define
// DMEM_STATS_EN to add saturating load/store/error counters.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0] ld_count,
  output logic [15:0] st_count,
  output logic [15:0] err_count
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              wr_q;
  logic [1:0]        size_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [31:0]       old_q;

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_word;
  logic [31:0] merged;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        accept;
  logic        req_err;

  assign accept = req_valid && req_ready;

  // Misalignment, reserved size and out-of-range are all judged on the raw
  // request so the decision is frozen together with the other latched fields.
  always_comb begin
    case (req_size)
      SZ_WORD: req_err = (req_addr[1:0] != 2'b00);
      SZ_HALF: req_err = req_addr[0];
      SZ_BYTE: req_err = 1'b0;
      default: req_err = 1'b1;
    endcase
    if ((req_addr >> (ADDR_W + 2)) != 32'd0) req_err = 1'b1;
  end

  dmem_lane_merge u_lane_merge (
    .old_word (old_q),
    .wdata    (wdata_q),
    .size     (size_q),
    .offset   (off_q),
    .merged   (merged)
  );

  assign rd_word   = mem[idx_q];
  assign mem_we    = (state == ST_ACCESS && wr_q && size_q == SZ_WORD) || (state == ST_MERGE);
  assign mem_wdata = (state == ST_MERGE) ? merged : wdata_q;

  // NOTE: the array is deliberately left out of reset; only the write enable
  // is gated so a commit coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[idx_q] <= mem_wdata;
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      wr_q      <= 1'b0;
      size_q    <= SZ_WORD;
      off_q     <= 2'b00;
      idx_q     <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      old_q     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            wr_q      <= req_wr;
            size_q    <= req_size;
            off_q     <= req_addr[1:0];
            idx_q     <= req_addr[ADDR_W+1:2];
            wdata_q   <= req_wdata;
            err_q     <= req_err;
            wait_cnt  <= '0;
            req_ready <= 1'b0;
            if (WAIT_CYCLES != 0) begin
              state <= ST_WAIT;
            end else if (req_err) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state <= ST_ACCESS;
            end
          end
        end

        ST_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= '0;
            if (err_q) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state <= ST_ACCESS;
            end
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        ST_ACCESS: begin
          if (wr_q && size_q != SZ_WORD) begin
            old_q <= rd_word;
            state <= ST_MERGE;
          end else begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= wr_q ? wdata_q : rd_word;
          end
        end

        ST_MERGE: begin
          state     <= ST_RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= merged;
        end

        ST_RESP: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end

        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef DMEM_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // rsp_err is already valid during RESP, so it classifies the transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_count  <= '0;
      st_count  <= '0;
      err_count <= '0;
    end else if (state == ST_RESP) begin
      if (rsp_err)   err_count <= sat_inc(err_count);
      else if (wr_q) st_count  <= sat_inc(st_count);
      else           ld_count  <= sat_inc(ld_count);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 1 uses one wait state, instance 0 none;
// both are compared against a word-array model of the load/store rules.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DEPTH = 256;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  lat;
  } vec_t;

  localparam vec_t DIR_TBL [16] = '{
    '{1'b1, SZ_WORD, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 4'd3},
    '{1'b1, SZ_WORD, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 4'd3},
    '{1'b0, SZ_WORD, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 4'd3},
    '{1'b1, SZ_BYTE, 32'h0000_0011, 32'hAAAA_AA55, 32'hDEAD_55EF, 1'b0, 4'd4},
    '{1'b0, SZ_WORD, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_55EF, 1'b0, 4'd3},
    '{1'b1, SZ_HALF, 32'h0000_0012, 32'hCCCC_1234, 32'h1234_55EF, 1'b0, 4'd4},
    '{1'b1, SZ_HALF, 32'h0000_0013, 32'h0000_9999, 32'h0000_0000, 1'b1, 4'd2},
    '{1'b0, SZ_WORD, 32'h0000_0010, 32'h0000_0000, 32'h1234_55EF, 1'b0, 4'd3},
    '{1'b1, SZ_WORD, 32'h0000_0400, 32'h1111_1111, 32'h0000_0000, 1'b1, 4'd2},
    '{1'b1, SZ_RSVD, 32'h0000_0010, 32'h2222_2222, 32'h0000_0000, 1'b1, 4'd2},
    '{1'b0, SZ_WORD, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 4'd3},
    '{1'b0, SZ_WORD, 32'h0000_0010, 32'h0000_0000, 32'h1234_55EF, 1'b0, 4'd3},
    '{1'b0, SZ_WORD, 32'h0000_0012, 32'h0000_0000, 32'h0000_0000, 1'b1, 4'd2},
    '{1'b1, SZ_BYTE, 32'h0000_0013, 32'h6666_6677, 32'h7734_55EF, 1'b0, 4'd4},
    '{1'b0, SZ_HALF, 32'h0000_0012, 32'h0000_0000, 32'h7734_55EF, 1'b0, 4'd3},
    '{1'b0, SZ_BYTE, 32'h0000_0011, 32'h0000_0000, 32'h7734_55EF, 1'b0, 4'd3}
  };

  logic        clk;
  logic        reset_a     [2];
  logic        req_valid_a [2];
  logic        req_wr_a    [2];
  logic [1:0]  req_size_a  [2];
  logic [31:0] req_addr_a  [2];
  logic [31:0] req_wdata_a [2];
  wire         req_ready_a [2];
  wire         rsp_valid_a [2];
  wire  [31:0] rsp_rdata_a [2];
  wire         rsp_err_a   [2];
`ifdef DMEM_STATS_EN
  wire  [15:0] ld_cnt_a    [2];
  wire  [15:0] st_cnt_a    [2];
  wire  [15:0] err_cnt_a   [2];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model [2][DEPTH];
  int exp_ld [2];
  int exp_st [2];
  int exp_er [2];

  dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset_a[0]),
    .req_valid(req_valid_a[0]), .req_ready(req_ready_a[0]), .req_wr(req_wr_a[0]),
    .req_size(req_size_a[0]), .req_addr(req_addr_a[0]), .req_wdata(req_wdata_a[0]),
    .rsp_valid(rsp_valid_a[0]), .rsp_rdata(rsp_rdata_a[0]), .rsp_err(rsp_err_a[0])
`ifdef DMEM_STATS_EN
    , .ld_count(ld_cnt_a[0]), .st_count(st_cnt_a[0]), .err_count(err_cnt_a[0])
`endif
  );

  dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset_a[1]),
    .req_valid(req_valid_a[1]), .req_ready(req_ready_a[1]), .req_wr(req_wr_a[1]),
    .req_size(req_size_a[1]), .req_addr(req_addr_a[1]), .req_wdata(req_wdata_a[1]),
    .rsp_valid(rsp_valid_a[1]), .rsp_rdata(rsp_rdata_a[1]), .rsp_err(rsp_err_a[1])
`ifdef DMEM_STATS_EN
    , .ld_count(ld_cnt_a[1]), .st_count(st_cnt_a[1]), .err_count(err_cnt_a[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int waits(input int sel);
    return (sel == 0) ? 0 : 1;
  endfunction

  // Reference: expected response and latency from the access rules, updating the word array.
  task automatic model_apply(input int sel, input logic wr, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata, output logic err, output int lat);
    int unsigned idx, off;
    logic [31:0] w;
    err = (size == SZ_RSVD) || (size == SZ_WORD && (addr % 4) != 0) ||
          (size == SZ_HALF && (addr % 2) != 0) || (addr >= 32'(4 * DEPTH));
    rdata = 32'h0;
    if (err) begin
      lat = waits(sel) + 1;
      exp_er[sel]++;
      return;
    end
    lat = waits(sel) + 2;
    idx = addr / 4;
    off = addr % 4;
    w   = model[sel][idx];
    if (wr) begin
      if (size == SZ_WORD)      w = wdata;
      else if (size == SZ_HALF) w[8*off +: 16] = wdata[15:0];
      else                      w[8*off +: 8]  = wdata[7:0];
      if (size != SZ_WORD) lat++;
      model[sel][idx] = w;
      exp_st[sel]++;
    end else begin
      exp_ld[sel]++;
    end
    rdata = w;
  endtask

  // Issues one request, scrambles the inputs after acceptance, and measures
  // latency from the accept edge; hold_ok covers the cycle after the response.
  task automatic do_req(input int sel, input logic wr, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output logic hold_ok);
    int guard = 0;
    @(negedge clk);
    while (req_ready_a[sel] !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    req_valid_a[sel] = 1'b1;
    req_wr_a[sel]    = wr;
    req_size_a[sel]  = size;
    req_addr_a[sel]  = addr;
    req_wdata_a[sel] = wdata;
    @(posedge clk);
    #1;
    req_valid_a[sel] = 1'b0;
    req_wr_a[sel]    = 1'($urandom_range(0, 1));
    req_size_a[sel]  = 2'($urandom_range(0, 3));
    req_addr_a[sel]  = $urandom;
    req_wdata_a[sel] = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (rsp_valid_a[sel] !== 1'b1 && lat < 50);
    rdata = rsp_rdata_a[sel];
    err   = rsp_err_a[sel];
    @(negedge clk);
    hold_ok = (rsp_valid_a[sel] === 1'b0) && (req_ready_a[sel] === 1'b1) &&
              (rsp_rdata_a[sel] === rdata) && (rsp_err_a[sel] === err);
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      reset_a[s]     = 1'b1;
      req_valid_a[s] = 1'b0;
      req_wr_a[s]    = 1'b0;
      req_size_a[s]  = SZ_WORD;
      req_addr_a[s]  = 32'h0;
      req_wdata_a[s] = 32'h0;
      exp_ld[s] = 0;
      exp_st[s] = 0;
      exp_er[s] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_a[0] = 1'b0;
    reset_a[1] = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (req_ready_a[s] !== 1'b1 || rsp_valid_a[s] !== 1'b0 ||
          rsp_rdata_a[s] !== 32'h0 || rsp_err_a[s] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: ready=%b valid=%b rdata=%h err=%b, expected 1 0 00000000 0",
                 s, req_ready_a[s], rsp_valid_a[s], rsp_rdata_a[s], rsp_err_a[s]);
      end
`ifdef DMEM_STATS_EN
      n_checks++;
      if (ld_cnt_a[s] !== 16'h0 || st_cnt_a[s] !== 16'h0 || err_cnt_a[s] !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_counters dut%0d: ld=%0d st=%0d err=%0d, expected 0 0 0",
                 s, ld_cnt_a[s], st_cnt_a[s], err_cnt_a[s]);
      end
`endif
    end
  endtask

  task automatic test_directed();
    logic [31:0] o_rd, m_rd;
    logic o_err, o_ok, m_err;
    int o_lat, m_lat;
    foreach (DIR_TBL[i]) begin
      do_req(1, DIR_TBL[i].wr, DIR_TBL[i].size, DIR_TBL[i].addr, DIR_TBL[i].wdata,
             o_rd, o_err, o_lat, o_ok);
      model_apply(1, DIR_TBL[i].wr, DIR_TBL[i].size, DIR_TBL[i].addr, DIR_TBL[i].wdata,
                  m_rd, m_err, m_lat);
      n_checks++;
      if (o_rd !== DIR_TBL[i].rdata || o_err !== DIR_TBL[i].err ||
          o_lat != int'(DIR_TBL[i].lat) || !o_ok) begin
        n_fail++;
        $display("FAIL directed[%0d] addr=%h: rdata=%h err=%b lat=%0d hold=%b, expected rdata=%h err=%b lat=%0d hold=1",
                 i, DIR_TBL[i].addr, o_rd, o_err, o_lat, o_ok,
                 DIR_TBL[i].rdata, DIR_TBL[i].err, DIR_TBL[i].lat);
      end
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] o_rd, e_rd, wd;
    logic o_err, o_ok, e_err;
    int o_lat, e_lat;
    logic        ops_wr   [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0]  ops_size [7] = '{SZ_WORD, SZ_WORD, SZ_BYTE, SZ_WORD, SZ_HALF, SZ_WORD, SZ_HALF};
    logic [31:0] ops_addr [7] = '{32'h20, 32'h20, 32'h22, 32'h20, 32'h21, 32'h800, 32'h20};
    for (int i = 0; i < 7; i++) begin
      wd = $urandom;
      do_req(0, ops_wr[i], ops_size[i], ops_addr[i], wd, o_rd, o_err, o_lat, o_ok);
      model_apply(0, ops_wr[i], ops_size[i], ops_addr[i], wd, e_rd, e_err, e_lat);
      n_checks++;
      if (o_rd !== e_rd || o_err !== e_err || o_lat != e_lat || !o_ok) begin
        n_fail++;
        $display("FAIL zero_wait[%0d] addr=%h: rdata=%h err=%b lat=%0d hold=%b, expected rdata=%h err=%b lat=%0d hold=1",
                 i, ops_addr[i], o_rd, o_err, o_lat, o_ok, e_rd, e_err, e_lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] o_rd, e1, e2, e_rd, seen_rd;
    logic o_err, o_ok, e_err;
    int o_lat, e_lat, t, pulses;
    do_req(1, 1'b1, SZ_WORD, 32'h14, 32'hCAFE_0014, o_rd, o_err, o_lat, o_ok);
    model_apply(1, 1'b1, SZ_WORD, 32'h14, 32'hCAFE_0014, e_rd, e_err, e_lat);
    n_checks++;
    if (o_rd !== e_rd || o_err !== e_err || o_lat != e_lat || !o_ok) begin
      n_fail++;
      $display("FAIL b2b_setup: rdata=%h err=%b lat=%0d, expected %h %b %0d", o_rd, o_err, o_lat, e_rd, e_err, e_lat);
    end
    model_apply(1, 1'b0, SZ_WORD, 32'h10, 32'h0, e1, e_err, e_lat);
    model_apply(1, 1'b0, SZ_WORD, 32'h14, 32'h0, e2, e_err, e_lat);

    req_valid_a[1] = 1'b1;
    req_wr_a[1]    = 1'b0;
    req_size_a[1]  = SZ_WORD;
    req_addr_a[1]  = 32'h10;
    t = 0;
    do begin @(negedge clk); t++; end while (rsp_valid_a[1] !== 1'b1 && t < 50);
    n_checks++;
    if (t != 3 || rsp_rdata_a[1] !== e1 || req_ready_a[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first: lat=%0d rdata=%h ready=%b, expected 3 %h 0", t, rsp_rdata_a[1], req_ready_a[1], e1);
    end
    req_addr_a[1] = 32'h14;
    @(negedge clk);
    n_checks++;
    if (req_ready_a[1] !== 1'b1 || rsp_valid_a[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: ready=%b valid=%b, expected 1 0", req_ready_a[1], rsp_valid_a[1]);
    end
    t = 0;
    do begin @(negedge clk); t++; end while (rsp_valid_a[1] !== 1'b1 && t < 50);
    req_valid_a[1] = 1'b0;
    n_checks++;
    if (t != 3 || rsp_rdata_a[1] !== e2) begin
      n_fail++;
      $display("FAIL b2b_second: lat=%0d rdata=%h, expected 3 %h", t, rsp_rdata_a[1], e2);
    end

    // A request raised while busy must be dropped, not queued.
    model_apply(1, 1'b0, SZ_WORD, 32'h10, 32'h0, e1, e_err, e_lat);
    @(negedge clk);
    @(negedge clk);
    req_valid_a[1] = 1'b1;
    req_addr_a[1]  = 32'h10;
    @(posedge clk);
    #1;
    req_wr_a[1]    = 1'b1;
    req_addr_a[1]  = 32'h14;
    req_wdata_a[1] = 32'h0BAD_0BAD;
    @(posedge clk);
    #1;
    req_valid_a[1] = 1'b0;
    pulses  = 0;
    seen_rd = 32'h0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid_a[1] === 1'b1) begin
        pulses++;
        seen_rd = rsp_rdata_a[1];
      end
    end
    n_checks++;
    if (pulses != 1 || seen_rd !== e1) begin
      n_fail++;
      $display("FAIL busy_ignored: responses=%0d rdata=%h, expected 1 %h", pulses, seen_rd, e1);
    end
    do_req(1, 1'b0, SZ_WORD, 32'h14, 32'h0, o_rd, o_err, o_lat, o_ok);
    model_apply(1, 1'b0, SZ_WORD, 32'h14, 32'h0, e_rd, e_err, e_lat);
    n_checks++;
    if (o_rd !== e_rd || o_err !== e_err || o_lat != e_lat || !o_ok) begin
      n_fail++;
      $display("FAIL busy_no_write: rdata=%h err=%b lat=%0d, expected %h %b %0d", o_rd, o_err, o_lat, e_rd, e_err, e_lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] o_rd, e_rd;
    logic o_err, o_ok, e_err;
    int o_lat, e_lat, pulses, guard;
    guard = 0;
    @(negedge clk);
    while (req_ready_a[1] !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    req_valid_a[1] = 1'b1;
    req_wr_a[1]    = 1'b1;
    req_size_a[1]  = SZ_BYTE;
    req_addr_a[1]  = 32'h11;
    req_wdata_a[1] = 32'h0000_00A5;
    @(posedge clk);
    #1;
    req_valid_a[1] = 1'b0;
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid_a[1] === 1'b1) pulses++;
    end
    reset_a[1] = 1'b1;
    @(negedge clk);
    reset_a[1] = 1'b0;
    exp_ld[1] = 0;
    exp_st[1] = 0;
    exp_er[1] = 0;
    @(negedge clk);
    n_checks++;
    if (req_ready_a[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_ready: ready=%b, expected 1", req_ready_a[1]);
    end
`ifdef DMEM_STATS_EN
    n_checks++;
    if (ld_cnt_a[1] !== 16'h0 || st_cnt_a[1] !== 16'h0 || err_cnt_a[1] !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_mid_counters: ld=%0d st=%0d err=%0d, expected 0 0 0", ld_cnt_a[1], st_cnt_a[1], err_cnt_a[1]);
    end
`endif
    repeat (5) begin
      if (rsp_valid_a[1] === 1'b1) pulses++;
      @(negedge clk);
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_rsp: responses=%0d, expected 0", pulses);
    end
    do_req(1, 1'b0, SZ_WORD, 32'h10, 32'h0, o_rd, o_err, o_lat, o_ok);
    model_apply(1, 1'b0, SZ_WORD, 32'h10, 32'h0, e_rd, e_err, e_lat);
    n_checks++;
    if (o_rd !== e_rd || o_err !== e_err || o_lat != e_lat || !o_ok) begin
      n_fail++;
      $display("FAIL reset_mid_unchanged: rdata=%h err=%b lat=%0d, expected %h %b %0d", o_rd, o_err, o_lat, e_rd, e_err, e_lat);
    end
  endtask

  task automatic test_random();
    logic [31:0] o_rd, e_rd, addr, wd;
    logic o_err, o_ok, e_err, wr;
    logic [1:0] size;
    int o_lat, e_lat, r;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 46; i++) begin
        wd = $urandom;
        if (i < 16) begin
          wr   = 1'b1;
          size = SZ_WORD;
          addr = 32'(4 * i);
        end else begin
          r    = $urandom_range(0, 9);
          wr   = 1'($urandom_range(0, 1));
          size = 2'($urandom_range(0, 3));
          if (r == 0)      addr = 32'h400 + 32'($urandom_range(0, 1023));
          else if (r == 1) addr = $urandom;
          else             addr = 32'($urandom_range(0, 63));
        end
        do_req(s, wr, size, addr, wd, o_rd, o_err, o_lat, o_ok);
        model_apply(s, wr, size, addr, wd, e_rd, e_err, e_lat);
        n_checks++;
        if (o_rd !== e_rd || o_err !== e_err || o_lat != e_lat || !o_ok) begin
          n_fail++;
          $display("FAIL random dut%0d[%0d] wr=%b size=%0d addr=%h: rdata=%h err=%b lat=%0d hold=%b, expected rdata=%h err=%b lat=%0d hold=1",
                   s, i, wr, size, addr, o_rd, o_err, o_lat, o_ok, e_rd, e_err, e_lat);
        end
      end
`ifdef DMEM_STATS_EN
      n_checks++;
      if (int'(ld_cnt_a[s]) != exp_ld[s] || int'(st_cnt_a[s]) != exp_st[s] || int'(err_cnt_a[s]) != exp_er[s]) begin
        n_fail++;
        $display("FAIL counters dut%0d: ld=%0d st=%0d err=%0d, expected %0d %0d %0d",
                 s, ld_cnt_a[s], st_cnt_a[s], err_cnt_a[s], exp_ld[s], exp_st[s], exp_er[s]);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_wait();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the target side of the CPU's load/store interface.
- Accepts one request at a time over a valid/ready handshake and serves it from an internal word array after a configurable number of wait states.
- Byte and halfword stores are done as read-modify-write.
- Returns one response pulse per request, carrying the aligned word and an error flag.

Parameters:
- ADDR_W, 8, word-index bits; array depth is 2**ADDR_W words, byte space is 2**(ADDR_W+2).
- WAIT_CYCLES, 1, wait states inserted between accept and array access (0 allowed).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; registered; high only in IDLE.
- req_wr  in  1  1 = store, 0 = load.
- req_size  in  2  00 word, 01 halfword, 10 byte, 11 reserved (error).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; byte/half taken from bits [7:0]/[15:0].
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  loads: aligned word read; stores: word as written; errors: 0.
- rsp_err  out  1  valid with rsp_valid; misaligned, out of range, or reserved size.

Behaviour:
- **Reset values:** req_ready=1 from the first cycle after reset deasserts; rsp_valid=0; rsp_rdata=0; rsp_err=0; state=IDLE; wait counter=0. Array contents are not cleared.
- **Acceptance:** a request is taken on the edge where req_valid && req_ready. req_wr, req_size, req_addr and req_wdata are latched at that edge only; later changes are ignored. req_valid while req_ready=0 is ignored and not queued.
- **FSM:** IDLE -> WAIT (skipped if WAIT_CYCLES=0) -> ACCESS -> [MERGE] -> RESP -> IDLE.
- **Error check:** performed at acceptance.
  - Word access with addr[1:0]!=0 is an error.
  - Half access with addr[0]!=0 is an error.
  - Size 11 is an error.
  - Any addr[31:ADDR_W+2]!=0 is an error.
  - An error request goes WAIT -> RESP, skips ACCESS, and performs no write.
- **Timing:** let T be the accept edge.
  - WAIT occupies cycles T+1..T+W, where W = WAIT_CYCLES.
  - ACCESS is cycle T+W+1.
  - Load / word store: RESP at T+W+2.
  - Byte/half store: MERGE at T+W+2, RESP at T+W+3.
  - Error: RESP at T+W+1.
  - req_ready returns high the cycle after RESP.
- **Array:** synchronous read, one cycle.
  - Word store writes at the end of ACCESS.
  - Partial store reads in ACCESS, writes the merged word at the end of MERGE.
- **Byte order:** little-endian. Byte offset k occupies bits [8k+7:8k]; halfword offset 2 occupies [31:16].
- **Response:** rsp_valid is high for exactly one cycle. There is no response backpressure. rsp_rdata and rsp_err hold their values until the next RESP.
- **Reset mid-operation:** reset at any edge aborts the transaction and returns to IDLE. No response is issued. A write whose commit edge coincides with reset is suppressed.

Optional Feature:
- Macro DMEM_STATS_EN.
- When defined, the block adds output ports ld_count[15:0], st_count[15:0] and err_count[15:0]. Each counter increments at RESP for successful loads, successful stores and errors respectively. Counters saturate at 16'hFFFF and clear on reset.
- When undefined, these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package dmem_pkg holds:
  - size encodings SZ_WORD, SZ_HALF, SZ_BYTE;
  - the FSM state enum;
  - the function that produces the byte-lane mask from size and offset.
- One combinational sub-module, dmem_lane_merge: inputs old word, wdata, size and offset; output merged word.

Test Plan:
- Word store 0x0000_0010 <- 0xDEADBEEF, then load 0x10 (W=1) -> load rsp_valid at T+3 with rdata 0xDEADBEEF, err=0.
- Byte store 0x11 <- 0x55 over 0xDEADBEEF -> store rsp at T+4 with rdata 0xDEAD55EF; a following word load returns 0xDEAD55EF.
- Half store 0x12 <- 0x1234 -> 0x123455EF. Half store at 0x13 -> rsp at T+2 with err=1, rdata=0; a reload confirms the word is unchanged.
- Out-of-range addr 0x0000_0400 (ADDR_W=8) and size 11 -> err=1, no write.
- Back-to-back requests with req_valid held high -> second accepted one cycle after first RESP. With W=0, load latency is 2.
- Reset asserted during MERGE of a byte store -> no rsp_valid, word unchanged, req_ready=1 after reset. With DMEM_STATS_EN, counters read 0.
